// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory controller command path: DRAM command codes,
// scheduler FSM states and the per-bank open-row entry.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        CMD_READ      = 3'd0,
        CMD_WRITE     = 3'd1,
        CMD_ACTIVATE  = 3'd2,
        CMD_PRECHARGE = 3'd3,
        CMD_NOP       = 3'b111
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        PRE_ISSUE,
        PRE_WAIT,
        ACT_ISSUE,
        ACT_WAIT,
        COL_ISSUE
    } sched_state_t;

    // Row width held in each open-row entry; the scheduler's ROW_BITS must match.
    localparam int OPEN_ROW_BITS = 8;

    typedef struct packed {
        logic                     valid;
        logic [OPEN_ROW_BITS-1:0] row;
    } open_row_t;

endpackage

// File: rtl/address_parser.sv
// Splits a physical address into DRAM fields.
// Layout from LSB upward: column, bank, bank group, row; higher bits are ignored.
module address_parser #(
    parameter int PADDR_BITS = 64,
    parameter int ROW_BITS   = 8,
    parameter int COL_BITS   = 4,
    parameter int BG_BITS    = 2,
    parameter int BA_BITS    = 1
) (
    input  logic [PADDR_BITS-1:0] i_paddr,
    output logic [ROW_BITS-1:0]   o_row,
    output logic [COL_BITS-1:0]   o_col,
    output logic [BG_BITS-1:0]    o_bg,
    output logic [BA_BITS-1:0]    o_ba
);
    localparam int BA_LSB  = COL_BITS;
    localparam int BG_LSB  = BA_LSB + BA_BITS;
    localparam int ROW_LSB = BG_LSB + BG_BITS;
    localparam int USED    = ROW_LSB + ROW_BITS;

    logic w_unused_hi;

    assign o_col       = i_paddr[COL_BITS-1:0];
    assign o_ba        = i_paddr[BG_LSB-1:BA_LSB];
    assign o_bg        = i_paddr[ROW_LSB-1:BG_LSB];
    assign o_row       = i_paddr[USED-1:ROW_LSB];
    assign w_unused_hi = ^i_paddr[PADDR_BITS-1:USED];

endmodule

// File: rtl/open_row_table.sv
// Per-bank open-row tracking: one {valid,row} entry per bank, combinational
// lookup, registered set (ACTIVATE) and clear (PRECHARGE).
module open_row_table
    import mem_ctrl_pkg::*;
#(
    parameter int NUM_BANKS = 8,
    parameter int IDX_BITS  = 3
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [IDX_BITS-1:0]      i_lookup_idx,
    output open_row_t                o_lookup,
    input  logic                     i_set,
    input  logic [IDX_BITS-1:0]      i_set_idx,
    input  logic [OPEN_ROW_BITS-1:0] i_set_row,
    input  logic                     i_clr,
    input  logic [IDX_BITS-1:0]      i_clr_idx
);
    open_row_t r_entry [NUM_BANKS];

    // Entry update: ACTIVATE opens a row, PRECHARGE closes the bank.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NUM_BANKS; i++) begin
                r_entry[i] <= '0;
            end
        end else begin
            if (i_set) begin
                r_entry[i_set_idx].valid <= 1'b1;
                r_entry[i_set_idx].row   <= i_set_row;
            end
            if (i_clr) begin
                r_entry[i_clr_idx].valid <= 1'b0;
            end
        end
    end

    assign o_lookup = r_entry[i_lookup_idx];

endmodule

// File: rtl/bank_cmd_scheduler.sv
// In-order DRAM command scheduler: accepts one line request at a time and
// emits PRECHARGE/ACTIVATE/READ/WRITE with latency and burst spacing enforced.
module bank_cmd_scheduler
    import mem_ctrl_pkg::*;
#(
    parameter int ACTIVATION_LATENCY = 8,
    parameter int PRECHARGE_LATENCY  = 5,
    parameter int BURST_CYCLES       = 8,
    parameter int BANK_GROUPS        = 4,
    parameter int BANKS_PER_GROUP    = 2,
    parameter int ROW_BITS           = 8,
    parameter int COL_BITS           = 4,
    parameter int PADDR_BITS         = 64
) (
    input  logic                               clk_in,
    input  logic                               rst_N_in,
    input  logic                               req_valid_in,
    output logic                               req_ready_out,
    input  logic [PADDR_BITS-1:0]              req_addr_in,
    input  logic                               req_write_in,
    input  logic [7:0][63:0]                   req_data_in,
    input  logic                               bursting_in,
    output logic [$clog2(BANK_GROUPS)-1:0]     bank_group_out,
    output logic [$clog2(BANKS_PER_GROUP)-1:0] bank_out,
    output logic [ROW_BITS-1:0]                row_out,
    output logic [COL_BITS-1:0]                col_out,
    output logic [2:0]                         cmd_out,
    output logic                               valid_out,
    output logic [7:0][63:0]                   val_out
);
    localparam int BG_BITS   = $clog2(BANK_GROUPS);
    localparam int BA_BITS   = $clog2(BANKS_PER_GROUP);
    localparam int IDX_BITS  = BG_BITS + BA_BITS;
    localparam int NUM_BANKS = BANK_GROUPS * BANKS_PER_GROUP;
    localparam int WAIT_MAX  = (ACTIVATION_LATENCY > PRECHARGE_LATENCY) ?
                               ACTIVATION_LATENCY : PRECHARGE_LATENCY;
    localparam int WAIT_BITS = $clog2(WAIT_MAX + 1);
    localparam int GAP_BITS  = $clog2(BURST_CYCLES + 1);

    sched_state_t           r_state;
    sched_state_t           w_next_state;
    cmd_t                   w_cmd;
    logic [WAIT_BITS-1:0]   r_wait_cnt;
    logic [GAP_BITS-1:0]    r_gap;

    logic [BG_BITS-1:0]     r_bg;
    logic [BA_BITS-1:0]     r_ba;
    logic [ROW_BITS-1:0]    r_row;
    logic [COL_BITS-1:0]    r_col;
    logic                   r_write;
    logic [7:0][63:0]       r_data;

    logic [BG_BITS-1:0]     w_bg;
    logic [BA_BITS-1:0]     w_ba;
    logic [ROW_BITS-1:0]    w_row;
    logic [COL_BITS-1:0]    w_col;
    open_row_t              w_lookup;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_col_go;

    address_parser #(
        .PADDR_BITS (PADDR_BITS),
        .ROW_BITS   (ROW_BITS),
        .COL_BITS   (COL_BITS),
        .BG_BITS    (BG_BITS),
        .BA_BITS    (BA_BITS)
    ) u_addr_parser (
        .i_paddr (req_addr_in),
        .o_row   (w_row),
        .o_col   (w_col),
        .o_bg    (w_bg),
        .o_ba    (w_ba)
    );

    open_row_table #(
        .NUM_BANKS (NUM_BANKS),
        .IDX_BITS  (IDX_BITS)
    ) u_open_rows (
        .i_clk        (clk_in),
        .i_rst_n      (rst_N_in),
        .i_lookup_idx ({w_bg, w_ba}),
        .o_lookup     (w_lookup),
        .i_set        (r_state == ACT_ISSUE),
        .i_set_idx    ({r_bg, r_ba}),
        .i_set_row    (r_row),
        .i_clr        (r_state == PRE_ISSUE),
        .i_clr_idx    ({r_bg, r_ba})
    );

    assign w_ready  = (r_state == IDLE) && (r_gap == '0);
    assign w_accept = req_valid_in && w_ready;
    assign w_col_go = (r_state == COL_ISSUE) && (r_gap == '0) && !bursting_in;

    // State register.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and command decode; the open-row lookup picks the entry path.
    always_comb begin
        w_next_state = r_state;
        w_cmd        = CMD_NOP;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_lookup.valid && (w_lookup.row == w_row)) begin
                        w_next_state = COL_ISSUE;
                    end else if (!w_lookup.valid) begin
                        w_next_state = ACT_ISSUE;
                    end else begin
                        w_next_state = PRE_ISSUE;
                    end
                end
            end
            PRE_ISSUE: begin
                w_cmd        = CMD_PRECHARGE;
                w_next_state = PRE_WAIT;
            end
            PRE_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_next_state = ACT_ISSUE;
                end
            end
            ACT_ISSUE: begin
                w_cmd        = CMD_ACTIVATE;
                w_next_state = ACT_WAIT;
            end
            ACT_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_next_state = COL_ISSUE;
                end
            end
            COL_ISSUE: begin
                if (w_col_go) begin
                    w_cmd        = r_write ? CMD_WRITE : CMD_READ;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Latency counter: loaded while issuing PRE/ACT, counts down through the wait state.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            r_wait_cnt <= '0;
        end else if (r_state == PRE_ISSUE) begin
            r_wait_cnt <= WAIT_BITS'(PRECHARGE_LATENCY - 1);
        end else if (r_state == ACT_ISSUE) begin
            r_wait_cnt <= WAIT_BITS'(ACTIVATION_LATENCY - 1);
        end else if (r_wait_cnt != '0) begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
        end
    end

    // Column spacing counter: reloaded after each column command, saturates at zero.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            r_gap <= '0;
        end else if (w_col_go) begin
            r_gap <= GAP_BITS'(BURST_CYCLES - 1);
        end else if (r_gap != '0) begin
            r_gap <= r_gap - 1'b1;
        end
    end

    // Request capture on handshake; held until the next accepted request.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            r_bg    <= '0;
            r_ba    <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_write <= 1'b0;
            r_data  <= '0;
        end else if (w_accept) begin
            r_bg    <= w_bg;
            r_ba    <= w_ba;
            r_row   <= w_row;
            r_col   <= w_col;
            r_write <= req_write_in;
            r_data  <= req_data_in;
        end
    end

    assign req_ready_out  = w_ready;
    assign cmd_out        = w_cmd;
    assign valid_out      = (w_cmd != CMD_NOP);
    assign bank_group_out = r_bg;
    assign bank_out       = r_ba;
    assign row_out        = r_row;
    assign col_out        = r_col;
    assign val_out        = r_data;

endmodule

// File: tb/tb_bank_cmd_scheduler.sv
// Self-checking bench for bank_cmd_scheduler: directed scenarios plus a random
// request stream, checked against a timeline model of open rows and latencies.
module tb_bank_cmd_scheduler;

    localparam int ACT_LAT = 8;
    localparam int PRE_LAT = 5;
    localparam int BURST   = 8;

    logic             clk_in = 1'b0;
    logic             rst_N_in;
    logic             req_valid_in;
    logic             req_ready_out;
    logic [63:0]      req_addr_in;
    logic             req_write_in;
    logic [7:0][63:0] req_data_in;
    logic             bursting_in;
    logic [1:0]       bank_group_out;
    logic [0:0]       bank_out;
    logic [7:0]       row_out;
    logic [3:0]       col_out;
    logic [2:0]       cmd_out;
    logic             valid_out;
    logic [7:0][63:0] val_out;

    int checks   = 0;
    int failures = 0;

    // Reference model: which row is open in each bank.
    bit m_valid [8];
    int m_row   [8];

    always #5 clk_in = ~clk_in;

    bank_cmd_scheduler #(
        .ACTIVATION_LATENCY (ACT_LAT),
        .PRECHARGE_LATENCY  (PRE_LAT),
        .BURST_CYCLES       (BURST),
        .BANK_GROUPS        (4),
        .BANKS_PER_GROUP    (2),
        .ROW_BITS           (8),
        .COL_BITS           (4),
        .PADDR_BITS         (64)
    ) dut (
        .clk_in         (clk_in),
        .rst_N_in       (rst_N_in),
        .req_valid_in   (req_valid_in),
        .req_ready_out  (req_ready_out),
        .req_addr_in    (req_addr_in),
        .req_write_in   (req_write_in),
        .req_data_in    (req_data_in),
        .bursting_in    (bursting_in),
        .bank_group_out (bank_group_out),
        .bank_out       (bank_out),
        .row_out        (row_out),
        .col_out        (col_out),
        .cmd_out        (cmd_out),
        .valid_out      (valid_out),
        .val_out        (val_out)
    );

    function automatic logic [7:0][63:0] rand_line();
        logic [7:0][63:0] d;
        for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
        return d;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_row[i]   = 0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk_in);
        #1 rst_N_in = 1'b0;
        req_valid_in = 1'b0;
        bursting_in  = 1'b0;
        @(negedge clk_in);
        #1 rst_N_in = 1'b1;
        model_clear();
    endtask

    // One request: predicts PRE/ACT/column cycles from the open-row model,
    // holds bursting_in for 'stall' cycles at the column slot, and checks every
    // cycle until ready returns.
    task automatic do_req(input logic [63:0] addr, input bit wr,
                          input logic [7:0][63:0] data, input int stall, input string tag);
        int col, ba, bg, row, bank;
        int pre_t, act_t, c0, col_t, waited;
        logic [2:0] exp_cmd;
        logic       exp_ready;
        col  = int'(addr % 64'd16);
        ba   = int'((addr >> 4) % 64'd2);
        bg   = int'((addr >> 5) % 64'd4);
        row  = int'((addr >> 7) % 64'd256);
        bank = bg * 2 + ba;
        pre_t = -1;
        act_t = -1;
        if (m_valid[bank] && m_row[bank] == row) begin
            c0 = 1;
        end else if (!m_valid[bank]) begin
            act_t = 1;
            c0    = 2 + ACT_LAT;
        end else begin
            pre_t = 1;
            act_t = 2 + PRE_LAT;
            c0    = 3 + PRE_LAT + ACT_LAT;
        end
        col_t = c0 + stall;

        waited = 0;
        while (req_ready_out !== 1'b1 && waited < 200) begin
            @(negedge clk_in);
            waited++;
        end
        checks++;
        if (req_ready_out !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_wait got=%b expected=1", tag, req_ready_out);
            return;
        end
        req_valid_in = 1'b1;
        req_addr_in  = addr;
        req_write_in = wr;
        req_data_in  = data;

        for (int t = 1; t <= col_t + BURST; t++) begin
            @(posedge clk_in);
            #1;
            req_valid_in = (t < col_t + BURST) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_addr_in  = {$urandom, $urandom};
            req_write_in = 1'($urandom_range(0, 1));
            req_data_in  = rand_line();
            if (t >= c0 && t < col_t)  bursting_in = 1'b1;
            else if (t == col_t)       bursting_in = 1'b0;
            else                       bursting_in = 1'($urandom_range(0, 1));
            @(negedge clk_in);
            if (t == pre_t)      exp_cmd = 3'd3;
            else if (t == act_t) exp_cmd = 3'd2;
            else if (t == col_t) exp_cmd = wr ? 3'd1 : 3'd0;
            else                 exp_cmd = 3'd7;
            checks++;
            if (cmd_out !== exp_cmd || valid_out !== (exp_cmd != 3'd7)) begin
                failures++;
                $display("FAIL %s cmd t=%0d got=%0d/v%b expected=%0d", tag, t, cmd_out, valid_out, exp_cmd);
            end
            if (exp_cmd != 3'd7) begin
                checks++;
                if (bank_group_out !== 2'(bg) || bank_out !== 1'(ba) ||
                    row_out !== 8'(row) || col_out !== 4'(col)) begin
                    failures++;
                    $display("FAIL %s addr t=%0d got=bg%0d ba%0d r%0d c%0d expected=bg%0d ba%0d r%0d c%0d",
                             tag, t, bank_group_out, bank_out, row_out, col_out, bg, ba, row, col);
                end
            end
            exp_ready = (t == col_t + BURST);
            checks++;
            if (req_ready_out !== exp_ready) begin
                failures++;
                $display("FAIL %s ready t=%0d got=%b expected=%b", tag, t, req_ready_out, exp_ready);
            end
            checks++;
            if (val_out !== data) begin
                failures++;
                $display("FAIL %s val_out t=%0d got=%h expected=%h", tag, t, val_out[0], data[0]);
            end
        end
        req_valid_in = 1'b0;
        bursting_in  = 1'b0;
        m_valid[bank] = 1'b1;
        m_row[bank]   = row;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_in);
        checks++;
        if (cmd_out !== 3'd7 || valid_out !== 1'b0 || req_ready_out !== 1'b1) begin
            failures++;
            $display("FAIL reset_ctrl got=cmd%0d v%b r%b expected=cmd7 v0 r1", cmd_out, valid_out, req_ready_out);
        end
        checks++;
        if (bank_group_out !== '0 || bank_out !== '0 || row_out !== '0 ||
            col_out !== '0 || val_out !== '0) begin
            failures++;
            $display("FAIL reset_data got=bg%0d ba%0d r%0d c%0d v%h expected=0",
                     bank_group_out, bank_out, row_out, col_out, val_out[0]);
        end
        #1 rst_N_in = 1'b1;
        model_clear();
    endtask

    task automatic test_closed_read();
        do_req(64'h83, 1'b0, rand_line(), 0, "closed_read");
    endtask

    task automatic test_row_hit();
        do_req(64'h84, 1'b0, rand_line(), 0, "row_hit");
    endtask

    task automatic test_row_conflict();
        do_req(64'h103, 1'b0, rand_line(), 0, "row_conflict");
        do_req(64'h107, 1'b0, rand_line(), 0, "conflict_followup_hit");
    endtask

    task automatic test_write_stall();
        do_req(64'h105, 1'b1, rand_line(), 3, "write_stall");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        do_req(64'h83, 1'b0, rand_line(), 0, "b2b_bank0");
        do_req(64'h93, 1'b1, rand_line(), 0, "b2b_bank1");
    endtask

    task automatic test_reset_mid_sequence();
        logic [7:0][63:0] d;
        apply_reset();
        d = rand_line();
        @(negedge clk_in);
        req_valid_in = 1'b1;
        req_addr_in  = 64'h83;
        req_write_in = 1'b0;
        req_data_in  = d;
        @(posedge clk_in);
        #1 req_valid_in = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        checks++;
        if (req_ready_out !== 1'b0) begin
            failures++;
            $display("FAIL midrst_busy ready got=%b expected=0", req_ready_out);
        end
        #1 rst_N_in = 1'b0;
        #1;
        checks++;
        if (cmd_out !== 3'd7 || valid_out !== 1'b0 || req_ready_out !== 1'b1) begin
            failures++;
            $display("FAIL midrst_async got=cmd%0d v%b r%b expected=cmd7 v0 r1", cmd_out, valid_out, req_ready_out);
        end
        checks++;
        if (row_out !== '0 || val_out !== '0) begin
            failures++;
            $display("FAIL midrst_clear got=r%0d v%h expected=0", row_out, val_out[0]);
        end
        #1 rst_N_in = 1'b1;
        model_clear();
        do_req(64'h83, 1'b0, rand_line(), 0, "midrst_reopen");
    endtask

    task automatic test_random();
        logic [63:0] addr;
        for (int n = 0; n < 40; n++) begin
            addr = {$urandom, $urandom};
            addr[14:7] = 8'($urandom_range(0, 2));
            addr[6:4]  = 3'($urandom_range(0, 7));
            repeat ($urandom_range(0, 3)) @(negedge clk_in);
            do_req(addr, 1'($urandom_range(0, 1)), rand_line(), int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        rst_N_in     = 1'b0;
        req_valid_in = 1'b0;
        req_addr_in  = '0;
        req_write_in = 1'b0;
        req_data_in  = '0;
        bursting_in  = 1'b0;
        test_reset();
        test_closed_read();
        test_row_hit();
        test_row_conflict();
        test_write_stall();
        test_back_to_back();
        test_reset_mid_sequence();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
